instruction_encoder: RTL

- Packs MIPS instruction fields (opcode, registers, shamt/funct, immediate, jump target) into 32-bit R/I/J words.
- Streams the words as sequential single-cycle writes into the program memory write port, starting at a base address.
- Lets the bench and boot logic fill program memory from field-level stimulus, so the opcode decoding path is exercised against independently built words.
- One instruction is accepted per clock through a valid/ready handshake; a small state machine handles session start, overflow and completion.

---
 rtl/instruction_encoder.sv | 121 ++++++++++++
 1 files changed

// File: rtl/instruction_encoder.sv
// ============================================================================
// Module      : instruction_encoder
// Description : Packs MIPS R/I/J fields into 32-bit words and streams them into
//               the program memory write port from a base address.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_encoder #(
  parameter int          MEMORY_DEPTH = 64,
  parameter logic [31:0] BASE_ADDRESS = 32'h0040_0000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [1:0]                      Format,
  input  logic [5:0]                      OP,
  input  logic [4:0]                      RS,
  input  logic [4:0]                      RT,
  input  logic [4:0]                      RD,
  input  logic [4:0]                      Shamt,
  input  logic [5:0]                      Funct,
  input  logic [15:0]                     Immediate,
  input  logic [25:0]                     Target,
  input  logic                            last,
  output logic                            MemWrite,
  output logic [31:0]                     WriteAddress,
  output logic [31:0]                     WriteData,
  output logic [$clog2(MEMORY_DEPTH):0]   Count,
  output logic                            busy,
  output logic                            done,
  output logic                            error
);

  localparam int COUNT_W = $clog2(MEMORY_DEPTH) + 1;
  localparam logic [COUNT_W-1:0] c_depth = COUNT_W'(MEMORY_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_memWrite;
  logic [31:0]         r_writeAddress;
  logic [31:0]         r_writeData;
  logic [COUNT_W-1:0]  r_count;
  logic                r_done;
  logic                r_error;

  logic                w_accept;
  logic                w_legal;
  logic                w_room;
  logic [31:0]         w_encoded;
  logic [31:0]         w_nextAddress;

  // start wins over a same-cycle bundle, so the handshake is withheld then.
  assign in_ready      = (r_state == LOAD) && !start;
  assign w_accept      = in_valid && in_ready;
  assign w_legal       = (Format != 2'd3);
  assign w_room        = (r_count < c_depth);
  assign w_nextAddress = BASE_ADDRESS + {{(30-COUNT_W){1'b0}}, r_count, 2'b00};

  always_comb begin
    w_encoded = 32'd0;
    case (Format)
      2'd0:    w_encoded = {OP, RS, RT, RD, Shamt, Funct};
      2'd1:    w_encoded = {OP, RS, RT, Immediate};
      2'd2:    w_encoded = {OP, Target};
      default: w_encoded = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_memWrite     <= 1'b0;
      r_writeAddress <= BASE_ADDRESS;
      r_writeData    <= 32'd0;
      r_count        <= '0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      r_memWrite <= 1'b0;
      if (start) begin
        r_state <= LOAD;
        r_count <= '0;
        r_done  <= 1'b0;
        r_error <= 1'b0;
      end else if (w_accept) begin
        if (w_legal && w_room) begin
          r_memWrite     <= 1'b1;
          r_writeAddress <= w_nextAddress;
          r_writeData    <= w_encoded;
          r_count        <= r_count + 1'b1;
        end else begin
          r_error <= 1'b1;
        end
        // Illegal or overflow bundles still close the session when flagged last.
        if (last) begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end
      end
    end
  end

  assign MemWrite     = r_memWrite;
  assign WriteAddress = r_writeAddress;
  assign WriteData    = r_writeData;
  assign Count        = r_count;
  assign busy         = (r_state == LOAD);
  assign done         = r_done;
  assign error        = r_error;

endmodule

`default_nettype wire
